// File: rtl/rv523_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv523_reg_pkg
//  Description : Mode encoding and NAND helpers for the RV523 register slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv523_reg_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_HOLD  = 2'b00;
    localparam mode_t MODE_LOAD  = 2'b01;
    localparam mode_t MODE_SHIFT = 2'b10;
    localparam mode_t MODE_COUNT = 2'b11;

    function automatic logic nand2(input logic a, input logic b);
        return ~(a & b);
    endfunction

    function automatic logic nand4(input logic a, input logic b,
                                   input logic c, input logic e);
        return ~(a & b & c & e);
    endfunction

endpackage
`default_nettype wire

// File: rtl/nand_reg_bit.sv
`default_nettype none
// ============================================================================
//  Module      : nand_reg_bit
//  Description : One state bit: NAND-only 4:1 mode mux, increment half-adder
//                and synchronous-reset flop.
//  Revision    : 1.0 - initial release
// ============================================================================
module nand_reg_bit
    import rv523_reg_pkg::*;
#(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic  clk,
    input  logic  rst_n,
    input  mode_t mode,
    input  logic  d,
    input  logic  shift_in,
    input  logic  cin,
    output logic  q,
    output logic  cout
);

    logic r_q;
    logic w_m1n, w_m0n;
    logic w_hold_n, w_load_n, w_shift_n, w_count_n;
    logic w_sel_hold, w_sel_load, w_sel_shift, w_sel_count;
    logic w_x1, w_x2, w_x3, w_inc;
    logic w_t0, w_t1, w_t2, w_t3, w_next;

    assign w_m1n       = nand2(mode[1], mode[1]);
    assign w_m0n       = nand2(mode[0], mode[0]);
    assign w_hold_n    = nand2(w_m1n,   w_m0n);
    assign w_load_n    = nand2(w_m1n,   mode[0]);
    assign w_shift_n   = nand2(mode[1], w_m0n);
    assign w_count_n   = nand2(mode[1], mode[0]);
    assign w_sel_hold  = nand2(w_hold_n,  w_hold_n);
    assign w_sel_load  = nand2(w_load_n,  w_load_n);
    assign w_sel_shift = nand2(w_shift_n, w_shift_n);
    assign w_sel_count = nand2(w_count_n, w_count_n);

    // Four-NAND XOR gives q ^ cin; its first stage also yields q & cin.
    assign w_x1  = nand2(r_q, cin);
    assign w_x2  = nand2(r_q, w_x1);
    assign w_x3  = nand2(cin, w_x1);
    assign w_inc = nand2(w_x2, w_x3);
    assign cout  = nand2(w_x1, w_x1);

    // Unselected terms are gated by a 0 select, so an X on d outside load cannot leak.
    assign w_t0   = nand2(r_q,      w_sel_hold);
    assign w_t1   = nand2(d,        w_sel_load);
    assign w_t2   = nand2(shift_in, w_sel_shift);
    assign w_t3   = nand2(w_inc,    w_sel_count);
    assign w_next = nand4(w_t0, w_t1, w_t2, w_t3);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= RESET_BIT;
        end else begin
            r_q <= w_next;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/nand_reg_slice_n.sv
`default_nettype none
// ============================================================================
//  Module      : nand_reg_slice_n
//  Description : WIDTH-bit hold/load/shift/count register with carry pulse
//                and optional saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module nand_reg_slice_n
    import rv523_reg_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               SATURATE    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             scan_in,
    output logic [WIDTH-1:0] q,
    output logic             scan_out,
    output logic             carry_out,
    output logic             at_max
);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_shift_in;
    logic [WIDTH:0]   w_carry;
    logic             w_is_count;
    logic             w_sat_hold;
    mode_t            w_mode_eff;
    logic             r_carry_out;

    // Carry into bit 0 is a constant 1, so the chain output doubles as all-ones detect.
    assign w_carry[0] = 1'b1;
    assign w_shift_in = {w_q[WIDTH-2:0], scan_in};
    assign w_is_count = (mode == MODE_COUNT);
    assign w_sat_hold = w_is_count && w_carry[WIDTH] && (SATURATE != 0);
    assign w_mode_eff = w_sat_hold ? MODE_HOLD : mode;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            nand_reg_bit #(
                .RESET_BIT (RESET_VALUE[gi])
            ) u_bit (
                .clk      (clk),
                .rst_n    (rst_n),
                .mode     (w_mode_eff),
                .d        (d[gi]),
                .shift_in (w_shift_in[gi]),
                .cin      (w_carry[gi]),
                .q        (w_q[gi]),
                .cout     (w_carry[gi+1])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_carry_out <= 1'b0;
        end else begin
            r_carry_out <= w_is_count && w_carry[WIDTH] && (SATURATE == 0);
        end
    end

    assign q         = w_q;
    assign scan_out  = w_q[WIDTH-1];
    assign at_max    = w_carry[WIDTH];
    assign carry_out = r_carry_out;

endmodule
`default_nettype wire
